mem_bus_arbiter: RTL and testbench

- Two-master arbiter and sequencer for the shared memory0 port (en/rw/size/abus/dbus).
- Master 0 is the cpu0 load/store/fetch path; master 1 is a DMA/loader/debug requester.
- Grants the port round-robin and drives one memory transaction at a time through a fixed state sequence.
- Returns per-master ack, read data and error.

---
 rtl/mem_bus_arbiter_if.sv | 49 ++++
 rtl/mem_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of both requester ports and the memory0 port seen by mem_bus_arbiter.
// Single-cycle req/ack handshake per master; no backpressure beyond holding req until ack.
interface mem_bus_arbiter_if;
    logic        m0_req;
    logic        m0_rw;
    logic [1:0]  m0_size;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_ack;
    logic        m0_err;
    logic [31:0] m0_rdata;

    logic        m1_req;
    logic        m1_rw;
    logic [1:0]  m1_size;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_ack;
    logic        m1_err;
    logic [31:0] m1_rdata;

    logic        mem_en;
    logic        mem_rw;
    logic [1:0]  mem_size;
    logic [31:0] mem_abus;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    modport slave (
        input  m0_req, m0_rw, m0_size, m0_addr, m0_wdata,
        output m0_ack, m0_err, m0_rdata,
        input  m1_req, m1_rw, m1_size, m1_addr, m1_wdata,
        output m1_ack, m1_err, m1_rdata,
        output mem_en, mem_rw, mem_size, mem_abus, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output m0_req, m0_rw, m0_size, m0_addr, m0_wdata,
        input  m0_ack, m0_err, m0_rdata,
        output m1_req, m1_rw, m1_size, m1_addr, m1_wdata,
        input  m1_ack, m1_err, m1_rdata,
        input  mem_en, mem_rw, mem_size, mem_abus, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin two-master sequencer for memory0; ack WAIT_CYCLES clocks after grant, one transaction per WAIT_CYCLES+2 clocks.
// Losing master simply keeps req high until served; out-of-range addresses are acked with err and never reach memory.
module mem_bus_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] MEM_LIMIT   = 32'h10000
) (
    input  logic             clock,
    input  logic             reset,
    mem_bus_arbiter_if.slave bus
);
    localparam logic [31:0] ADDR_MAX  = MEM_LIMIT - 32'd4;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        winner_q, winner_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_rw_q, mem_rw_d;
    logic [1:0]  mem_size_q, mem_size_d;
    logic [31:0] mem_abus_q, mem_abus_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]  ack_q, ack_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        busy_q, busy_d;
    logic        gnt;
    logic [31:0] sel_addr;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            winner_q     <= 1'b0;
            wcnt_q       <= '0;
            mem_en_q     <= 1'b0;
            mem_rw_q     <= 1'b0;
            mem_size_q   <= '0;
            mem_abus_q   <= '0;
            mem_wdata_q  <= '0;
            ack_q        <= '0;
            err_q        <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            wcnt_q       <= wcnt_d;
            mem_en_q     <= mem_en_d;
            mem_rw_q     <= mem_rw_d;
            mem_size_q   <= mem_size_d;
            mem_abus_q   <= mem_abus_d;
            mem_wdata_q  <= mem_wdata_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        wcnt_d       = wcnt_q;
        mem_en_d     = mem_en_q;
        mem_rw_d     = mem_rw_q;
        mem_size_d   = mem_size_q;
        mem_abus_d   = mem_abus_q;
        mem_wdata_d  = mem_wdata_q;
        ack_d        = '0;
        err_d        = '0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        busy_d       = busy_q;
        gnt          = 1'b0;
        sel_addr     = bus.m0_addr;

        case (state_q)
            IDLE: begin
                mem_en_d = 1'b0;
                busy_d   = 1'b0;
                if (bus.m0_req || bus.m1_req) begin
                    // On a tie the master that was not served last wins.
                    gnt         = (bus.m0_req && bus.m1_req) ? ~last_grant_q : bus.m1_req;
                    sel_addr    = gnt ? bus.m1_addr : bus.m0_addr;
                    winner_d    = gnt;
                    mem_rw_d    = gnt ? bus.m1_rw    : bus.m0_rw;
                    mem_size_d  = gnt ? bus.m1_size  : bus.m0_size;
                    mem_abus_d  = sel_addr;
                    mem_wdata_d = gnt ? bus.m1_wdata : bus.m0_wdata;
                    busy_d      = 1'b1;
                    if (sel_addr > ADDR_MAX) begin
                        state_d    = RESP;
                        ack_d[gnt] = 1'b1;
                        err_d[gnt] = 1'b1;
                        if (gnt) rdata1_d = '0;
                        else     rdata0_d = '0;
                    end else begin
                        state_d  = ACCESS;
                        mem_en_d = 1'b1;
                        wcnt_d   = WAIT_LOAD;
                    end
                end
            end
            ACCESS: begin
                if (wcnt_q == 4'd0) begin
                    state_d         = RESP;
                    mem_en_d        = 1'b0;
                    ack_d[winner_q] = 1'b1;
                    if (winner_q) rdata1_d = mem_rw_q ? bus.mem_rdata : '0;
                    else          rdata0_d = mem_rw_q ? bus.mem_rdata : '0;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            RESP: begin
                last_grant_d = winner_q;
                state_d      = IDLE;
                busy_d       = 1'b0;
            end
            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    assign bus.m0_ack    = ack_q[0];
    assign bus.m1_ack    = ack_q[1];
    assign bus.m0_err    = err_q[0];
    assign bus.m1_err    = err_q[1];
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_rdata  = rdata1_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_rw    = mem_rw_q;
    assign bus.mem_size  = mem_size_q;
    assign bus.mem_abus  = mem_abus_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a W=1 instance on a big-endian byte memory and a W=3 instance on an address-derived read pattern.
module tb_mem_bus_arbiter;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst1;
    logic rst3;
    int   checks = 0;
    int   errors = 0;

    mem_bus_arbiter_if if1 ();
    mem_bus_arbiter_if if3 ();

    mem_bus_arbiter #(.WAIT_CYCLES(1), .MEM_LIMIT(32'h10000)) dut1 (
        .clock (clock),
        .reset (rst1),
        .bus   (if1.slave)
    );

    mem_bus_arbiter #(.WAIT_CYCLES(3), .MEM_LIMIT(32'h10000)) dut3 (
        .clock (clock),
        .reset (rst3),
        .bus   (if3.slave)
    );

    bit [7:0] mem1 [512];

    function automatic logic [31:0] mem1_read(input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i <= int'(sz); i++) r = {r[23:0], mem1[9'(a + 32'(i))]};
        return r;
    endfunction

    assign if1.mem_rdata = (if1.mem_en && if1.mem_rw) ? mem1_read(if1.mem_abus, if1.mem_size) : 'x;
    assign if3.mem_rdata = (if3.mem_en && if3.mem_rw) ? (if3.mem_abus ^ 32'hA5A5_0000) : 'x;

    always @(posedge clock) begin
        if (rst1) begin
            mem1[0] <= 8'h09;
            mem1[1] <= 8'h10;
            mem1[2] <= 8'h00;
            mem1[3] <= 8'h04;
        end else if (if1.mem_en && !if1.mem_rw) begin
            for (int i = 0; i <= int'(if1.mem_size); i++)
                mem1[9'(if1.mem_abus + 32'(i))] <= if1.mem_wdata[8*(int'(if1.mem_size)-i) +: 8];
        end
    end

    typedef struct {
        logic        en;
        logic [31:0] abus;
        logic        busy;
        logic [1:0]  ack;
        logic [1:0]  err;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } obs_t;

    typedef struct {
        bit          m;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];

    function automatic obs_t sample(input bit sel);
        obs_t o;
        if (sel) begin
            o.en = if3.mem_en; o.abus = if3.mem_abus; o.busy = if3.busy;
            o.ack = {if3.m1_ack, if3.m0_ack}; o.err = {if3.m1_err, if3.m0_err};
            o.rd0 = if3.m0_rdata; o.rd1 = if3.m1_rdata;
        end else begin
            o.en = if1.mem_en; o.abus = if1.mem_abus; o.busy = if1.busy;
            o.ack = {if1.m1_ack, if1.m0_ack}; o.err = {if1.m1_err, if1.m0_err};
            o.rd0 = if1.m0_rdata; o.rd1 = if1.m1_rdata;
        end
        return o;
    endfunction

    task automatic step();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit sel, input bit m, input logic [31:0] rd, input logic e);
        exp_t x;
        x.m = m; x.rdata = rd; x.err = e;
        if (sel) q3.push_back(x);
        else     q1.push_back(x);
    endtask

    task automatic drive(input bit sel, input bit m, input logic on, input logic rw,
                         input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        case ({sel, m})
            2'b00: begin if1.m0_req = on; if1.m0_rw = rw; if1.m0_size = sz; if1.m0_addr = a; if1.m0_wdata = wd; end
            2'b01: begin if1.m1_req = on; if1.m1_rw = rw; if1.m1_size = sz; if1.m1_addr = a; if1.m1_wdata = wd; end
            2'b10: begin if3.m0_req = on; if3.m0_rw = rw; if3.m0_size = sz; if3.m0_addr = a; if3.m0_wdata = wd; end
            default: begin if3.m1_req = on; if3.m1_rw = rw; if3.m1_size = sz; if3.m1_addr = a; if3.m1_wdata = wd; end
        endcase
    endtask

    // Steps until an ack shows, then pops the scoreboard and checks the response and its timing.
    task automatic wait_ack(input bit sel, input string tag, input int exp_cyc, input int exp_en,
                            input logic [31:0] exp_abus);
        obs_t o;
        exp_t e;
        int   cyc = 0;
        int   en = 0;
        int   bz = 0;
        bit   found = 0;
        bit   m;
        int   qs;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            cyc++;
            o = sample(sel);
            if (o.busy) bz++;
            if (o.en) begin
                en++;
                chk({tag, "_abus"}, o.abus, exp_abus);
            end
            if (o.ack != 2'b00) found = 1;
        end
        chk({tag, "_acked"}, 32'(found), 32'd1);
        if (found) begin
            chk({tag, "_double_ack"}, 32'(o.ack == 2'b11), 32'd0);
            m  = o.ack[1];
            qs = sel ? q3.size() : q1.size();
            chk({tag, "_sb_entry"}, 32'(qs > 0), 32'd1);
            if (qs > 0) begin
                e = sel ? q3.pop_front() : q1.pop_front();
                chk({tag, "_master"}, 32'(m), 32'(e.m));
                chk({tag, "_rdata"}, m ? o.rd1 : o.rd0, e.rdata);
                chk({tag, "_err"}, 32'(o.err[m]), 32'(e.err));
                chk({tag, "_other_err"}, 32'(o.err[~m]), 32'd0);
            end
            chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
            chk({tag, "_en_cycles"}, 32'(en), 32'(exp_en));
            chk({tag, "_busy_cycles"}, 32'(bz), 32'(exp_en + 1));
        end
    endtask

    initial begin
        obs_t o;
        rst1 = 1'b1;
        rst3 = 1'b1;
        for (int s = 0; s < 2; s++) begin
            drive(s[0], 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
            drive(s[0], 1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        end
        repeat (3) step();

        o = sample(0);
        chk("rst_en", 32'(o.en), 32'd0);
        chk("rst_busy", 32'(o.busy), 32'd0);
        chk("rst_ack", 32'(o.ack), 32'd0);
        chk("rst_err", 32'(o.err), 32'd0);
        chk("rst_rd0", o.rd0, 32'd0);
        chk("rst_abus", o.abus, 32'd0);
        o = sample(1);
        chk("rst3_en_busy", 32'({o.en, o.busy}), 32'd0);
        rst1 = 1'b0;
        rst3 = 1'b0;

        // Single word read.
        drive(0, 0, 1, 1, 2'b11, 32'h0, 32'h0);
        push(0, 0, 32'h0910_0004, 1'b0);
        wait_ack(0, "rd0", 2, 1, 32'h0);
        drive(0, 0, 0, 0, 2'b00, 32'h0, 32'h0);
        step();
        o = sample(0);
        chk("rd0_busy_after", 32'(o.busy), 32'd0);
        chk("rd0_ack_after", 32'(o.ack), 32'd0);

        // Write then byte read-back through master 1.
        drive(0, 1, 1, 0, 2'b11, 32'h100, 32'hDEAD_BEEF);
        push(0, 1, 32'h0, 1'b0);
        wait_ack(0, "wr1", 2, 1, 32'h100);
        drive(0, 1, 0, 0, 2'b00, 32'h0, 32'h0);
        step();
        drive(0, 1, 1, 1, 2'b00, 32'h101, 32'h0);
        push(0, 1, 32'h0000_00AD, 1'b0);
        wait_ack(0, "rdb1", 2, 1, 32'h101);
        drive(0, 1, 0, 0, 2'b00, 32'h0, 32'h0);
        o = sample(0);
        chk("m0_rdata_kept", o.rd0, 32'h0910_0004);
        step();

        // Out of range and the last legal address.
        drive(0, 0, 1, 1, 2'b11, 32'hFFFD, 32'h0);
        push(0, 0, 32'h0, 1'b1);
        wait_ack(0, "oor", 1, 0, 32'h0);
        drive(0, 0, 0, 0, 2'b00, 32'h0, 32'h0);
        step();
        drive(0, 1, 1, 1, 2'b11, 32'hFFFC, 32'h0);
        push(0, 1, 32'h0, 1'b0);
        wait_ack(0, "lim", 2, 1, 32'hFFFC);
        drive(0, 1, 0, 0, 2'b00, 32'h0, 32'h0);
        step();

        // Continuous contention from reset alternates starting with master 0.
        rst1 = 1'b1;
        drive(0, 0, 1, 1, 2'b11, 32'h0, 32'h0);
        drive(0, 1, 1, 1, 2'b11, 32'h100, 32'h0);
        step();
        rst1 = 1'b0;
        for (int i = 0; i < 4; i++)
            push(0, i[0], i[0] ? 32'hDEAD_BEEF : 32'h0910_0004, 1'b0);
        for (int i = 0; i < 4; i++)
            wait_ack(0, "cont", (i == 0) ? 2 : 3, 1, i[0] ? 32'h100 : 32'h0);
        drive(0, 0, 0, 0, 2'b00, 32'h0, 32'h0);
        drive(0, 1, 0, 0, 2'b00, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            o = sample(0);
            chk("cont_quiet", 32'(o.ack), 32'd0);
        end

        // Three-cycle access on the W=3 instance.
        drive(1, 1, 1, 1, 2'b11, 32'h40, 32'h0);
        push(1, 1, 32'hA5A5_0040, 1'b0);
        wait_ack(1, "w3", 4, 3, 32'h40);
        drive(1, 1, 0, 0, 2'b00, 32'h0, 32'h0);
        step();
        o = sample(1);
        chk("w3_busy_after", 32'(o.busy), 32'd0);

        // Reset during the second access cycle abandons the transaction.
        drive(1, 1, 1, 1, 2'b11, 32'h80, 32'h0);
        step();
        o = sample(1);
        chk("mid_en_1", 32'(o.en), 32'd1);
        step();
        o = sample(1);
        chk("mid_en_2", 32'(o.en), 32'd1);
        rst3 = 1'b1;
        drive(1, 1, 0, 0, 2'b00, 32'h0, 32'h0);
        step();
        o = sample(1);
        chk("mid_rst_en", 32'(o.en), 32'd0);
        chk("mid_rst_busy", 32'(o.busy), 32'd0);
        chk("mid_rst_ack", 32'(o.ack), 32'd0);
        rst3 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            o = sample(1);
            chk("mid_no_ack", 32'(o.ack), 32'd0);
        end
        drive(1, 0, 1, 1, 2'b11, 32'h10, 32'h0);
        drive(1, 1, 1, 1, 2'b11, 32'h20, 32'h0);
        push(1, 0, 32'hA5A5_0010, 1'b0);
        push(1, 1, 32'hA5A5_0020, 1'b0);
        wait_ack(1, "post_rst_m0", 4, 3, 32'h10);
        drive(1, 0, 0, 0, 2'b00, 32'h0, 32'h0);
        wait_ack(1, "post_rst_m1", 5, 3, 32'h20);
        drive(1, 1, 0, 0, 2'b00, 32'h0, 32'h0);
        step();

        chk("sb_drained", 32'(q1.size() + q3.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
